mem_copy_engine: RTL
====================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001: Parameter AW, default 6, word-address width of the DataMemory port.
REQ-002: Parameter DW, default 32, data width of the DataMemory port.
REQ-003: One clock and one reset: reset is asynchronous and active-low; the clock port is CLK and the reset port is RST_N.
REQ-004: CLK  input  1  rising-edge clock shared with DataMemory.
REQ-005: RST_N  input  1  asynchronous active-low reset.
REQ-006: START  input  1  one-cycle copy request, sampled only in IDLE.
REQ-007: SRC  input  AW  first source word address, sampled with START.
REQ-008: DST  input  AW  first destination word address, sampled with START.
REQ-009: LEN  input  AW+1  word count, 0..2^AW, sampled with START.
REQ-010: BUSY  output  1  high from the cycle after an accepted START until DONE.
REQ-011: DONE  output  1  one-cycle pulse on copy completion.
REQ-012: A  output  AW  memory word address.
REQ-013: WE  output  1  memory write enable.
REQ-014: WD  output  DW  memory write data.
REQ-015: RD  input  DW  memory read data; combinational from A.

Function
REQ-016: FSM states are IDLE, RD_PH, WR_PH and FIN.
- IDLE + START + LEN>0 goes to RD_PH.
- IDLE + START + LEN==0 goes to FIN.
- RD_PH always goes to WR_PH.
- WR_PH goes to RD_PH if remaining count >1; otherwise it goes to FIN.
- FIN always goes to IDLE.
REQ-017: On an accepted START, the engine SHALL latch SRC, DST and LEN into internal src_ptr, dst_ptr and remaining registers.
REQ-018: RD_PH behaviour:
- A = src_ptr, WE = 0.
- RD is captured into a DW-bit hold register at the closing edge.
- src_ptr increments modulo 2^AW.
REQ-019: WR_PH behaviour:
- A = dst_ptr, WE = 1, WD = hold register.
- dst_ptr increments modulo 2^AW.
- remaining decrements by 1.
REQ-020: Throughput SHALL be exactly 2 cycles per word. A copy of N>0 words SHALL take 2N+1 cycles from the START edge to the DONE cycle inclusive of FIN.
REQ-021: DONE SHALL be high only in FIN. BUSY SHALL be high in RD_PH, WR_PH and FIN.
REQ-022: In IDLE and FIN the engine SHALL drive A=0, WE=0 and WD=0.
REQ-023: START while not IDLE SHALL be ignored, with no queuing.
REQ-024: Addresses SHALL wrap from 2^AW-1 to 0 with no error indication.
REQ-025: Copy order SHALL be strictly ascending. When ranges overlap with DST>SRC, already-written words are re-read (propagation semantics), and this is the defined behaviour.
REQ-026: LEN values above 2^AW SHALL be impossible by width. LEN=2^AW SHALL copy the whole memory.
REQ-027: WE SHALL never be high for more than one consecutive cycle.

Reset
REQ-028: Asserting RST_N low SHALL immediately force the following, independent of CLK:
- state=IDLE, BUSY=0, DONE=0, A=0, WE=0, WD=0.
- All pointers, the hold register and remaining cleared to 0.
REQ-029: Reset mid-copy SHALL abort with no further memory write and no DONE pulse. Words already written remain written.
REQ-030: After RST_N deasserts, the first START SHALL be accepted on the first rising edge.

Structure
REQ-031: The FSM state encoding and the AW/DW defaults SHALL live in a shared package (mips_mem_pkg) used by DataMemory and this block.
REQ-032: The block SHALL be a single module with no sub-modules. Benches SHALL instantiate it together with DataMemory (A/WE/WD/RD connected directly).

Verification
REQ-033: Preload mem[0..3]=10,20,30,40, then START SRC=0 DST=8 LEN=4. Required response: mem[8..11]=10,20,30,40 and DONE exactly 9 cycles after the START edge.
REQ-034: START LEN=0. Required response: DONE 1 cycle later, WE never asserted, memory unchanged.
REQ-035: Preload mem[62]=7 and mem[63]=9, then START SRC=62 DST=1 LEN=2. Required response: mem[1]=7, mem[2]=9. Then START SRC=0 DST=62 LEN=3. Required response: writes to 62, 63 and 0 (wrap).
REQ-036: Preload mem[0]=5, then START SRC=0 DST=1 LEN=4. Required response: mem[1..4]=5 (overlap propagation).
REQ-037: Pulse START again at cycle 3 of a LEN=4 copy. Required response: it is ignored and exactly one DONE is produced.
REQ-038: Assert RST_N low during WR_PH of word 2 of a LEN=4 copy. Required response: outputs are zero immediately, only word 1 and possibly word 2 are written, and no DONE occurs.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for DataMemory and mem_copy_engine.
//   MEM_AW / MEM_DW : default word-address and data widths of the DataMemory port
//   copy_state_e    : state encoding of the copy engine FSM
package mips_mem_pkg;

    localparam int unsigned MEM_AW = 6;
    localparam int unsigned MEM_DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_PH = 2'd1,
        WR_PH = 2'd2,
        FIN   = 2'd3
    } copy_state_e;

endpackage

// File: rtl/DataMemory.sv
// Single-port word memory: synchronous write, combinational read.
//   CLK : rising-edge clock
//   A   : word address
//   WE  : write enable (write on rising edge)
//   WD  : write data
//   RD  : read data, combinational from A
module DataMemory
    import mips_mem_pkg::*;
#(
    parameter int unsigned AW = MEM_AW,
    parameter int unsigned DW = MEM_DW
) (
    input  logic          CLK,
    input  logic [AW-1:0] A,
    input  logic          WE,
    input  logic [DW-1:0] WD,
    output logic [DW-1:0] RD
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [0:DEPTH-1];

    // Write port
    always_ff @(posedge CLK) begin
        if (WE) begin
            mem[A] <= WD;
        end
    end

    // Asynchronous read
    assign RD = mem[A];

endmodule

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine driving a single-port DataMemory.
// Each word takes a read phase (address = source, capture RD) followed by a
// write phase (address = destination, write captured word), ascending order.
//   CLK, RST_N      : clock, asynchronous active-low reset
//   START           : copy request, honoured only when idle
//   SRC, DST, LEN   : first source/destination word address and word count
//   BUSY, DONE      : copy in progress / one-cycle completion pulse
//   A, WE, WD, RD   : memory port (RD is combinational from A)
module mem_copy_engine
    import mips_mem_pkg::*;
#(
    parameter int unsigned AW = MEM_AW,
    parameter int unsigned DW = MEM_DW
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic [AW-1:0] SRC,
    input  logic [AW-1:0] DST,
    input  logic [AW:0]   LEN,
    output logic          BUSY,
    output logic          DONE,
    output logic [AW-1:0] A,
    output logic          WE,
    output logic [DW-1:0] WD,
    input  logic [DW-1:0] RD
);

    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    copy_state_e   state;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW:0]   remaining;
    logic [DW-1:0] hold;

    // Hold register is zero outside the write phase, so it doubles as WD
    assign WD = hold;

    // Copy FSM with registered memory-port and status outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            hold      <= '0;
            A         <= '0;
            WE        <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        src_ptr   <= SRC;
                        dst_ptr   <= DST;
                        remaining <= LEN;
                        BUSY      <= 1'b1;
                        if (LEN != '0) begin
                            state <= RD_PH;
                            A     <= SRC;
                        end else begin
                            state <= FIN;
                            DONE  <= 1'b1;
                        end
                    end
                end
                RD_PH: begin
                    hold    <= RD;
                    src_ptr <= src_ptr + PTR_ONE;
                    A       <= dst_ptr;
                    WE      <= 1'b1;
                    state   <= WR_PH;
                end
                WR_PH: begin
                    dst_ptr   <= dst_ptr + PTR_ONE;
                    remaining <= remaining - CNT_ONE;
                    hold      <= '0;
                    WE        <= 1'b0;
                    if (remaining > CNT_ONE) begin
                        A     <= src_ptr;
                        state <= RD_PH;
                    end else begin
                        A     <= '0;
                        DONE  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
